// File: rtl/port_reg_arbiter.sv
// Round-robin arbiter sharing one register-update bus among NPORT requesters.
// One transaction in flight; a watchdog aborts it if reg_ack never arrives.
module port_reg_arbiter #(
    parameter int NPORT   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT*7-1:0]  req_addr,
    input  logic [NPORT*16-1:0] req_din,
    input  logic [NPORT-1:0]    req,
    output logic [NPORT-1:0]    ack,
    output logic [6:0]          reg_addr,
    output logic [15:0]         reg_din,
    output logic                reg_req,
    input  logic                reg_ack,
    output logic [2:0]          grant_id,
    output logic                busy,
    output logic [7:0]          err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_GAP
    } state_t;

    localparam logic [2:0]       LAST_PORT = 3'(NPORT - 1);
    localparam logic [3:0]       NPORT_W   = 4'(NPORT);
    localparam logic [15:0]      WD_LAST   = 16'(TIMEOUT - 1);
    localparam logic [NPORT-1:0] ACK_ONE   = {{(NPORT-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NPORT-1:0]  r_ack;
    logic [NPORT-1:0]  w_ack_nxt;
    logic [6:0]        r_addr;
    logic [6:0]        w_addr_nxt;
    logic [15:0]       r_din;
    logic [15:0]       w_din_nxt;
    logic              r_reg_req;
    logic              w_reg_req_nxt;
    logic [2:0]        r_grant;
    logic [2:0]        w_grant_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic [7:0]        r_err;
    logic [7:0]        w_err_nxt;
    logic [15:0]       r_wdog;
    logic [15:0]       w_wdog_nxt;

    // Ports padded to 8 so a 3-bit index is always in range.
    logic [7:0]        w_req_pad;
    logic [6:0]        w_addr_arr [8];
    logic [15:0]       w_din_arr  [8];

    for (genvar g = 0; g < 8; g++) begin : g_pad
        if (g < NPORT) begin : g_on
            assign w_req_pad[g]  = req[g];
            assign w_addr_arr[g] = req_addr[7*g +: 7];
            assign w_din_arr[g]  = req_din[16*g +: 16];
        end else begin : g_off
            assign w_req_pad[g]  = 1'b0;
            assign w_addr_arr[g] = '0;
            assign w_din_arr[g]  = '0;
        end
    end

    // Search starts one past the last grant and wraps NPORT-1 -> 0.
    logic [3:0] w_rr_idx;
    logic [2:0] w_winner;
    logic       w_found;

    always_comb begin
        w_found  = 1'b0;
        w_winner = r_grant;
        w_rr_idx = '0;
        for (int k = 1; k <= NPORT; k++) begin
            w_rr_idx = {1'b0, r_grant} + 4'(k);
            if (w_rr_idx >= NPORT_W) begin
                w_rr_idx = w_rr_idx - NPORT_W;
            end
            if (!w_found && w_req_pad[w_rr_idx[2:0]]) begin
                w_found  = 1'b1;
                w_winner = w_rr_idx[2:0];
            end
        end
    end

    logic [NPORT-1:0] w_ack_sel;
    assign w_ack_sel = ACK_ONE << r_grant;

    always_comb begin
        w_state_nxt   = r_state;
        w_ack_nxt     = '0;
        w_addr_nxt    = r_addr;
        w_din_nxt     = r_din;
        w_reg_req_nxt = r_reg_req;
        w_grant_nxt   = r_grant;
        w_busy_nxt    = r_busy;
        w_err_nxt     = r_err;
        w_wdog_nxt    = r_wdog;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt   = w_winner;
                    w_addr_nxt    = w_addr_arr[w_winner];
                    w_din_nxt     = w_din_arr[w_winner];
                    w_reg_req_nxt = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_wdog_nxt    = '0;
                    w_state_nxt   = S_WAIT;
                end
            end
            S_WAIT: begin
                // A real acknowledge beats a simultaneous watchdog expiry.
                if (reg_ack) begin
                    w_reg_req_nxt = 1'b0;
                    w_ack_nxt     = w_ack_sel;
                    w_state_nxt   = S_ACK;
                end else if (r_wdog == WD_LAST) begin
                    w_reg_req_nxt = 1'b0;
                    w_ack_nxt     = w_ack_sel;
                    if (r_err != 8'hFF) begin
                        w_err_nxt = r_err + 8'd1;
                    end
                    w_state_nxt   = S_ACK;
                end else begin
                    w_wdog_nxt = r_wdog + 16'd1;
                end
            end
            S_ACK: begin
                w_state_nxt = S_GAP;
            end
            S_GAP: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ack     <= '0;
            r_addr    <= '0;
            r_din     <= '0;
            r_reg_req <= 1'b0;
            r_grant   <= LAST_PORT;
            r_busy    <= 1'b0;
            r_err     <= '0;
            r_wdog    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ack     <= w_ack_nxt;
            r_addr    <= w_addr_nxt;
            r_din     <= w_din_nxt;
            r_reg_req <= w_reg_req_nxt;
            r_grant   <= w_grant_nxt;
            r_busy    <= w_busy_nxt;
            r_err     <= w_err_nxt;
            r_wdog    <= w_wdog_nxt;
        end
    end

    assign ack      = r_ack;
    assign reg_addr = r_addr;
    assign reg_din  = r_din;
    assign reg_req  = r_reg_req;
    assign grant_id = r_grant;
    assign busy     = r_busy;
    assign err_cnt  = r_err;

endmodule

// File: tb/tb_port_reg_arbiter.sv
// Directed bench for port_reg_arbiter with an expected-grant scoreboard.
// Register-file responses are driven inline from the stimulus sequence.
module tb_port_reg_arbiter;

    localparam int NPORT   = 4;
    localparam int TIMEOUT = 255;

    logic                clk;
    logic                rst;
    logic [NPORT*7-1:0]  req_addr;
    logic [NPORT*16-1:0] req_din;
    logic [NPORT-1:0]    req;
    logic [NPORT-1:0]    ack;
    logic [6:0]          reg_addr;
    logic [15:0]         reg_din;
    logic                reg_req;
    logic                reg_ack;
    logic [2:0]          grant_id;
    logic                busy;
    logic [7:0]          err_cnt;

    typedef struct {
        int          port;
        logic [6:0]  addr;
        logic [15:0] din;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_err = 0;

    port_reg_arbiter #(
        .NPORT  (NPORT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_addr(req_addr),
        .req_din (req_din),
        .req     (req),
        .ack     (ack),
        .reg_addr(reg_addr),
        .reg_din (reg_din),
        .reg_req (reg_req),
        .reg_ack (reg_ack),
        .grant_id(grant_id),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [6:0] a,
                            input logic [15:0] d);
        req_addr[7*p +: 7]   = a;
        req_din[16*p +: 16]  = d;
    endtask

    task automatic push_exp(input int p);
        exp_t e;
        e.port = p;
        e.addr = req_addr[7*p +: 7];
        e.din  = req_din[16*p +: 16];
        sb.push_back(e);
    endtask

    task automatic wait_req(output int n, output exp_t e);
        e.port = -1;
        e.addr = '0;
        e.din  = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (reg_req !== 1'b1 && n < 40);
        check("req_seen", reg_req, 1);
        if (sb.size() > 0) e = sb.pop_front();
        check("grant", grant_id, e.port);
        check("addr", reg_addr, e.addr);
        check("din", reg_din, e.din);
        check("busy_on", busy, 1);
    endtask

    // Serve one transaction, returning reg_ack lat cycles after reg_req.
    task automatic serve(input int lat, output int n, output int port);
        exp_t e;
        logic [NPORT*7-1:0]  sa;
        logic [NPORT*16-1:0] sd;
        wait_req(n, e);
        port = e.port;
        sa = req_addr;
        sd = req_din;
        req_addr = ~sa;
        req_din  = ~sd;
        repeat (lat) begin
            @(negedge clk);
            check("req_hold", reg_req, 1);
        end
        reg_ack = 1'b1;
        @(negedge clk);
        reg_ack = 1'b0;
        check("ack", ack, 32'(1) << e.port);
        check("req_drop", reg_req, 0);
        check("addr_kept", reg_addr, e.addr);
        check("din_kept", reg_din, e.din);
        req_addr = sa;
        req_din  = sd;
    endtask

    task automatic timeout_txn();
        exp_t e;
        int   n;
        int   cnt;
        wait_req(n, e);
        cnt = 0;
        while (reg_req === 1'b1 && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        exp_err = (exp_err == 255) ? 255 : exp_err + 1;
        check("wd_len", cnt, TIMEOUT);
        check("to_ack", ack, 32'(1) << e.port);
        check("err_cnt", err_cnt, exp_err);
    endtask

    initial begin
        int n;
        int p;
        int last;
        int ack_cnt [NPORT];
        exp_t e;
        logic seen;

        rst      = 1'b1;
        req      = '0;
        req_addr = '0;
        req_din  = '0;
        reg_ack  = 1'b0;

        @(negedge clk);
        check("rst_grant", grant_id, NPORT - 1);
        check("rst_req", reg_req, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: nothing moves for 100 cycles.
        @(negedge clk);
        check("idle_addr", reg_addr, 0);
        check("idle_din", reg_din, 0);
        check("idle_ack", ack, 0);
        check("idle_grant", grant_id, 3);
        check("idle_err", err_cnt, 0);
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            seen = seen | busy | reg_req | (|ack);
        end
        check("idle_quiet", seen, 0);

        // Single write, ack 2 cycles late, 1-cycle request latency.
        set_port(0, 7'h10, 16'h00A5);
        req = 4'b0001;
        push_exp(0);
        serve(2, n, last);
        check("lat1", n, 1);
        req = '0;
        @(negedge clk);
        check("ack_pulse", ack, 0);
        check("busy_gap", busy, 1);
        @(negedge clk);
        check("busy_off", busy, 0);
        check("err_t2", err_cnt, 0);

        // All ports requesting: strict rotation.
        for (int i = 0; i < NPORT; i++) begin
            set_port(i, 7'(7'h20 + i), 16'(16'h1000 + i));
            ack_cnt[i] = 0;
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) push_exp((last + 1 + k) % NPORT);
        for (int k = 0; k < 5; k++) begin
            serve(0, n, p);
            for (int i = 0; i < NPORT; i++) if (ack[i]) ack_cnt[i]++;
            if (k == NPORT - 1) begin
                for (int i = 0; i < NPORT; i++) check("rr_once", ack_cnt[i], 1);
            end
            last = p;
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Silent target: watchdog abort.
        set_port(1, 7'h31, 16'h5A5A);
        req = 4'b0010;
        push_exp(1);
        timeout_txn();
        req = '0;
        repeat (3) @(negedge clk);

        // reg_ack in the same cycle the watchdog expires.
        req = 4'b0010;
        push_exp(1);
        wait_req(n, e);
        repeat (TIMEOUT - 1) @(negedge clk);
        reg_ack = 1'b1;
        @(negedge clk);
        reg_ack = 1'b0;
        req = '0;
        check("race_ack", ack, 4'b0010);
        check("race_err", err_cnt, exp_err);
        repeat (3) @(negedge clk);

        // Stray reg_ack while idle.
        reg_ack = 1'b1;
        @(negedge clk);
        reg_ack = 1'b0;
        check("stray_ack", ack, 0);
        check("stray_req", reg_req, 0);
        check("stray_busy", busy, 0);
        @(negedge clk);
        check("stray_err", err_cnt, exp_err);

        // Repeated timeouts saturate the error counter.
        req = 4'b0010;
        for (int r = 0; r < 259; r++) begin
            push_exp(1);
            timeout_txn();
        end
        req = '0;
        check("err_sat", err_cnt, 255);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-WAIT, then a pending port 2 wins.
        set_port(1, 7'h11, 16'h1111);
        req = 4'b0010;
        push_exp(1);
        wait_req(n, e);
        set_port(2, 7'h44, 16'hBEEF);
        req = 4'b0100;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        exp_err = 0;
        check("arst_req", reg_req, 0);
        check("arst_ack", ack, 0);
        check("arst_busy", busy, 0);
        check("arst_grant", grant_id, 3);
        check("arst_err", err_cnt, exp_err);
        @(negedge clk);
        rst = 1'b0;
        push_exp(2);
        serve(1, n, p);
        check("post_lat", n, 1);
        req = '0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
